// File: rtl/regfile_write_arbiter_if.sv
// Writeback-to-register-file bus: two valid/ready requesters, the clear
// command and the register file write port.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              clear_start;
  logic              clear_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_start,
    output req0_ready, req1_ready, clear_busy,
    output rf_we, rf_addr, rf_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_start,
    input  req0_ready, req1_ready, clear_busy,
    input  rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with x0 suppression
// and a zero-sweep clear sequencer.
//
// state    | meaning
// ST_ARB   | arbitrating writeback requests, one write per cycle
// ST_CLEAR | sweeping zero into every register, requesters stalled
module regfile_write_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last_grant;
  logic              r_clear_busy;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  logic w_same;
  logic w_grant0;
  logic w_grant1;
  logic w_open;
  logic w_accept0;
  logic w_accept1;

  // With both or neither valid, the requester that did not win last is granted.
  assign w_same    = (bus.req0_valid == bus.req1_valid);
  assign w_grant0  = (bus.req0_valid & ~bus.req1_valid) | (w_same &  r_last_grant);
  assign w_grant1  = (bus.req1_valid & ~bus.req0_valid) | (w_same & ~r_last_grant);
  assign w_open    = (r_state == ST_ARB) & ~bus.clear_start;
  assign w_accept0 = bus.req0_valid & bus.req0_ready;
  assign w_accept1 = bus.req1_valid & bus.req1_ready;

  assign bus.req0_ready = w_open & w_grant0;
  assign bus.req1_ready = w_open & w_grant1;
  assign bus.clear_busy = r_clear_busy;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_data    = r_rf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ARB;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_clear_busy <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_data    <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_rf_we <= 1'b0;
          if (bus.clear_start) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_clear_busy <= 1'b1;
          end else if (w_accept0) begin
            r_rf_addr    <= bus.req0_addr;
            r_rf_data    <= bus.req0_data;
            r_rf_we      <= (bus.req0_addr != '0);
            r_last_grant <= 1'b0;
          end else if (w_accept1) begin
            r_rf_addr    <= bus.req1_addr;
            r_rf_data    <= bus.req1_data;
            r_rf_we      <= (bus.req1_addr != '0);
            r_last_grant <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_rf_we   <= 1'b1;
          r_rf_addr <= r_cnt;
          r_rf_data <= '0;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
            r_state      <= ST_ARB;
            r_clear_busy <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_ARB;
          r_clear_busy <= 1'b0;
          r_rf_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule
